// File: rtl/div_iter_if.sv
// Execute-stage to divider handshake: operands and start/annul in, {remainder, quotient} with ready/busy out.
// The master side belongs to the execute stage and the slave side to the divider.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o,
        input  busy_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o,
        output busy_o
    );
endinterface

// File: rtl/div_iter.sv
// Restoring iterative divider, one quotient bit per clock: ready WIDTH+1 edges after start acceptance (1 edge for divide-by-zero).
// Stalls the pipeline via busy_o while working; the result is held in END until start_i drops, annul_i flushes ON/BYZERO.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_iter_if.slave  div_bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = WIDTH + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH+1:0]   shift_ext;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Magnitudes and one step of the shift/subtract datapath, computed every cycle.
    always_comb begin
        op1_neg   = div_bus.signed_div_i & div_bus.opdata1_i[WIDTH-1];
        op2_neg   = div_bus.signed_div_i & div_bus.opdata2_i[WIDTH-1];
        op1_abs   = op1_neg ? -div_bus.opdata1_i : div_bus.opdata1_i;
        op2_abs   = op2_neg ? -div_bus.opdata2_i : div_bus.opdata2_i;
        shift_ext = {rem_q, quo_q[WIDTH-1]};
        trial     = shift_ext - {2'b00, dsr_q};
        quo_fix   = neg_quo_q ? -quo_q : quo_q;
        rem_fix   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            ST_IDLE: begin
                if (div_bus.start_i && !div_bus.annul_i) begin
                    if (div_bus.opdata2_i == '0) begin
                        state_d = ST_BYZERO;
                    end else begin
                        state_d   = ST_ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = op1_abs;
                        dsr_d     = op2_abs;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
            end

            ST_BYZERO: begin
                if (div_bus.annul_i) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    state_d  = ST_END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end

            ST_ON: begin
                if (div_bus.annul_i) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_LAST) begin
                    // Sign bit of the widened trial tells whether the divisor fits.
                    rem_d = trial[WIDTH+1] ? RW'(shift_ext) : RW'(trial);
                    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d  = ST_END;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end

            ST_END: begin
                if (!div_bus.start_i) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign div_bus.result_o = result_q;
    assign div_bus.ready_o  = ready_q;
    assign div_bus.busy_o   = (state_q == ST_ON) || (state_q == ST_BYZERO);

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter at WIDTH 32 and 8 against an arithmetic reference built on 64-bit integer divide.
module tb_div_iter;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    div_iter_if #(.WIDTH(32)) bus32 ();
    div_iter_if #(.WIDTH(8))  bus8 ();

    div_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .div_bus(bus32.slave));
    div_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .div_bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {remainder, quotient} of a w-bit divide, truncating toward zero.
    function automatic logic [63:0] ref_div(input int w, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, q, r;
        logic [63:0] mask;
        if (b == 32'd0) return 64'd0;
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        if (sgn) begin
            sa = (sa <<< (64 - w)) >>> (64 - w);
            sb = (sb <<< (64 - w)) >>> (64 - w);
        end
        q = sa / sb;
        r = sa % sb;
        mask = (64'd1 << w) - 64'd1;
        return (($unsigned(r) & mask) << w) | ($unsigned(q) & mask);
    endfunction

    // Starts a 32-bit divide and waits for ready; lat counts edges after the acceptance edge.
    task automatic drive32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_n, output logic [63:0] res);
        int n;
        bus32.signed_div_i = sgn;
        bus32.opdata1_i    = a;
        bus32.opdata2_i    = b;
        bus32.start_i      = 1'b1;
        n = 0;
        busy_n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (bus32.busy_o) busy_n++;
        end while (!bus32.ready_o && n < 100);
        lat = n - 1;
        res = bus32.result_o;
    endtask

    task automatic finish32();
        bus32.start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drive8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] res);
        int n;
        bus8.signed_div_i = sgn;
        bus8.opdata1_i    = a;
        bus8.opdata2_i    = b;
        bus8.start_i      = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus8.ready_o && n < 50);
        lat = n - 1;
        res = bus8.result_o;
        bus8.start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus32.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready32 got %b want 0", bus32.ready_o); end
        n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy32 got %b want 0", bus32.busy_o); end
        n_checks++; if (bus32.result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result32 got %h want 0", bus32.result_o); end
        n_checks++; if (bus8.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready8 got %b want 0", bus8.ready_o); end
        n_checks++; if (bus8.result_o !== 16'd0) begin n_fail++; $display("FAIL reset_result8 got %h want 0", bus8.result_o); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_basic();
        int lat, busy_n;
        logic [63:0] res;
        drive32(1'b0, 32'd100, 32'd7, lat, busy_n, res);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL basic_latency got %0d want 33", lat); end
        n_checks++; if (busy_n !== 33) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 33", busy_n); end
        n_checks++; if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL basic_result got %h want %h", res, {32'd2, 32'd14}); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (bus32.ready_o !== 1'b1 || bus32.result_o !== {32'd2, 32'd14}) begin
                n_fail++; $display("FAIL basic_hold ready %b result %h want 1 %h", bus32.ready_o, bus32.result_o, {32'd2, 32'd14});
            end
        end
        finish32();
        n_checks++; if (bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0 || bus32.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL basic_clear ready %b busy %b result %h want 0 0 0", bus32.ready_o, bus32.busy_o, bus32.result_o);
        end
    endtask

    task automatic test_boundaries();
        logic        sgn_t [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] a_t   [6] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd1234};
        logic [31:0] b_t   [6] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFB, 32'd99999};
        logic [63:0] exp_t [6] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000000_80000000,
                                   64'h00000000_FFFFFFFF, 64'd0, {32'd1234, 32'd0}};
        int lat, busy_n;
        logic [63:0] res, mdl;
        for (int i = 0; i < 6; i++) begin
            drive32(sgn_t[i], a_t[i], b_t[i], lat, busy_n, res);
            mdl = ref_div(32, sgn_t[i], a_t[i], b_t[i]);
            n_checks++; if (res !== exp_t[i]) begin n_fail++; $display("FAIL boundary_%0d got %h want %h", i, res, exp_t[i]); end
            n_checks++; if (res !== mdl) begin n_fail++; $display("FAIL boundary_model_%0d got %h want %h", i, res, mdl); end
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL boundary_lat_%0d got %0d want 33", i, lat); end
            finish32();
        end
    endtask

    task automatic test_div_zero();
        int lat, busy_n;
        logic [63:0] res;
        for (int i = 0; i < 4; i++) begin
            drive32(i[0], $urandom, 32'd0, lat, busy_n, res);
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divzero_lat_%0d got %0d want 1", i, lat); end
            n_checks++; if (busy_n !== 1) begin n_fail++; $display("FAIL divzero_busy_%0d got %0d want 1", i, busy_n); end
            n_checks++; if (res !== 64'd0) begin n_fail++; $display("FAIL divzero_result_%0d got %h want 0", i, res); end
            finish32();
        end
    endtask

    task automatic test_random();
        int lat, busy_n, exp_lat;
        logic sgn;
        logic [31:0] a, b;
        logic [63:0] res, mdl;
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = -b;
            mdl = ref_div(32, sgn, a, b);
            exp_lat = (b == 32'd0) ? 1 : 33;
            drive32(sgn, a, b, lat, busy_n, res);
            n_checks++; if (res !== mdl || lat !== exp_lat) begin
                n_fail++; $display("FAIL random_%0d sgn %b %h/%h got %h lat %0d want %h lat %0d", i, sgn, a, b, res, lat, mdl, exp_lat);
            end
            finish32();
        end
    endtask

    task automatic test_width8();
        int lat;
        logic sgn;
        logic [7:0] a, b;
        logic [15:0] res;
        logic [63:0] mdl;
        drive8(1'b0, 8'd200, 8'd3, lat, res);
        n_checks++; if (res !== {8'd2, 8'd66}) begin n_fail++; $display("FAIL w8_200_3 got %h want %h", res, {8'd2, 8'd66}); end
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL w8_latency got %0d want 9", lat); end
        for (int i = 0; i < 20; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = 8'($urandom);
            b   = 8'($urandom);
            mdl = ref_div(8, sgn, {24'd0, a}, {24'd0, b});
            drive8(sgn, a, b, lat, res);
            n_checks++; if (res !== mdl[15:0]) begin
                n_fail++; $display("FAIL w8_random_%0d sgn %b %h/%h got %h want %h", i, sgn, a, b, res, mdl[15:0]);
            end
        end
    endtask

    task automatic test_annul();
        int lat, busy_n, rises;
        logic [63:0] res, mdl;
        bus32.signed_div_i = 1'b0;
        bus32.opdata1_i    = 32'd5000;
        bus32.opdata2_i    = 32'd9;
        bus32.start_i      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus32.start_i = 1'b0;
        bus32.annul_i = 1'b1;
        @(posedge clk); #1;
        bus32.annul_i = 1'b0;
        n_checks++; if (bus32.busy_o !== 1'b0 || bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
            n_fail++; $display("FAIL annul_on busy %b ready %b result %h want 0 0 0", bus32.busy_o, bus32.ready_o, bus32.result_o);
        end
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus32.ready_o) rises++;
        end
        n_checks++; if (rises !== 0) begin n_fail++; $display("FAIL annul_no_ready got %0d ready cycles want 0", rises); end
        // Start blocked while annul is high.
        bus32.start_i = 1'b1;
        bus32.annul_i = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL annul_idle_block got busy %b want 0", bus32.busy_o); end
        bus32.start_i = 1'b0;
        bus32.annul_i = 1'b0;
        @(posedge clk); #1;
        drive32(1'b1, 32'hFFFF0000, 32'd777, lat, busy_n, res);
        mdl = ref_div(32, 1'b1, 32'hFFFF0000, 32'd777);
        n_checks++; if (res !== mdl) begin n_fail++; $display("FAIL annul_restart got %h want %h", res, mdl); end
        // Annul during END has no effect.
        bus32.annul_i = 1'b1;
        @(posedge clk); #1;
        bus32.annul_i = 1'b0;
        n_checks++; if (bus32.ready_o !== 1'b1 || bus32.result_o !== mdl) begin
            n_fail++; $display("FAIL annul_end ready %b result %h want 1 %h", bus32.ready_o, bus32.result_o, mdl);
        end
        finish32();
        // Annul during BYZERO.
        bus32.opdata2_i = 32'd0;
        bus32.start_i   = 1'b1;
        @(posedge clk); #1;
        bus32.start_i = 1'b0;
        bus32.annul_i = 1'b1;
        @(posedge clk); #1;
        bus32.annul_i = 1'b0;
        n_checks++; if (bus32.ready_o !== 1'b0 || bus32.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL annul_byzero ready %b busy %b want 0 0", bus32.ready_o, bus32.busy_o);
        end
    endtask

    task automatic test_operand_change();
        int n;
        logic [63:0] mdl;
        mdl = ref_div(32, 1'b1, 32'h8765_4321, 32'h0000_1357);
        bus32.signed_div_i = 1'b1;
        bus32.opdata1_i    = 32'h8765_4321;
        bus32.opdata2_i    = 32'h0000_1357;
        bus32.start_i      = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            bus32.signed_div_i = 1'($urandom_range(0, 1));
            bus32.opdata1_i    = $urandom;
            bus32.opdata2_i    = $urandom;
        end while (!bus32.ready_o && n < 100);
        n_checks++; if (bus32.result_o !== mdl || n !== 34) begin
            n_fail++; $display("FAIL operand_change got %h after %0d edges want %h after 34", bus32.result_o, n, mdl);
        end
        finish32();
    endtask

    task automatic test_reset_mid();
        int lat, busy_n;
        logic [63:0] res, mdl;
        bus32.signed_div_i = 1'b0;
        bus32.opdata1_i    = 32'd99999;
        bus32.opdata2_i    = 32'd13;
        bus32.start_i      = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        bus32.start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_checks++; if (bus32.busy_o !== 1'b0 || bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
            n_fail++; $display("FAIL rst_mid_on busy %b ready %b result %h want 0 0 0", bus32.busy_o, bus32.ready_o, bus32.result_o);
        end
        @(posedge clk); #1;
        n_checks++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle_after got busy %b want 0", bus32.busy_o); end
        mdl = ref_div(32, 1'b0, 32'd99999, 32'd13);
        drive32(1'b0, 32'd99999, 32'd13, lat, busy_n, res);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (bus32.busy_o !== 1'b0 || bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
                n_fail++; $display("FAIL rst_end_%0d busy %b ready %b result %h want 0 0 0", i, bus32.busy_o, bus32.ready_o, bus32.result_o);
            end
        end
        rst = 1'b1;
        drive32(1'b0, 32'd99999, 32'd13, lat, busy_n, res);
        n_checks++; if (res !== mdl || lat !== 33) begin
            n_fail++; $display("FAIL rst_release_start got %h lat %0d want %h lat 33", res, lat, mdl);
        end
        finish32();
    endtask

    task automatic test_back_to_back();
        int lat, busy_n, total;
        logic [63:0] res, mdl;
        total = 0;
        for (int i = 0; i < 3; i++) begin
            mdl = ref_div(32, 1'b0, 32'd1000 + 32'(i), 32'd3 + 32'(i));
            drive32(1'b0, 32'd1000 + 32'(i), 32'd3 + 32'(i), lat, busy_n, res);
            total += lat + 1;
            n_checks++; if (res !== mdl) begin n_fail++; $display("FAIL b2b_%0d got %h want %h", i, res, mdl); end
            finish32();
            total += 1;
        end
        n_checks++; if (total !== 3 * 35) begin n_fail++; $display("FAIL b2b_spacing got %0d edges want %0d", total, 3 * 35); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus32.signed_div_i = 1'b0;
        bus32.opdata1_i    = '0;
        bus32.opdata2_i    = '0;
        bus32.start_i      = 1'b0;
        bus32.annul_i      = 1'b0;
        bus8.signed_div_i  = 1'b0;
        bus8.opdata1_i     = '0;
        bus8.opdata2_i     = '0;
        bus8.start_i       = 1'b0;
        bus8.annul_i       = 1'b0;

        test_reset();
        test_unsigned_basic();
        test_boundaries();
        test_div_zero();
        test_random();
        test_width8();
        test_annul();
        test_operand_change();
        test_reset_mid();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
